multi_write_buffer_controller: RTL and testbench

//  Parametrised successor to the single-channel write buffer controller.

---
 rtl/multi_write_buffer_controller.sv | 156 +++++++++++++++
 tb/tb_multi_write_buffer_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_write_buffer_controller.sv
// Round-robin write buffer controller: serves done pulses from NUM_CH channels one at a time,
// issuing tagged buffer writes with bounded retry/backoff and reporting completion or failure.
module multi_write_buffer_controller #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int MAX_RETRY      = 2,
  parameter int BACKOFF_CYCLES = 3,
  parameter int CNT_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic              buffer_ready,
  input  logic              fail_clr,
  output logic              buffer_write_en,
  output logic [CH_W-1:0]   buffer_ch_sel,
  output logic [1:0]        stall,
  output logic [NUM_CH-1:0] ch_ack,
  output logic              fail,
  output logic [CH_W-1:0]   fail_ch,
  output logic [CNT_W-1:0]  retry_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_GRANTED = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_FAIL    = 3'd6;

  logic [2:0]        state_reg, state_next;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]   sel_reg, sel_next;
  logic [CNT_W-1:0]  retry_reg, retry_next;
  logic [CNT_W-1:0]  backoff_reg, backoff_next;
  logic [CH_W-1:0]   fail_ch_reg, fail_ch_next;

  logic [CH_W-1:0]   rot_idx [NUM_CH];
  logic              arb_found;
  logic [CH_W-1:0]   arb_idx;
  logic [CH_W-1:0]   sel_inc;
  logic              release_req;

  // rot_idx[k] is the channel k places after rr_ptr, wrapping around NUM_CH
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    assign rot_idx[gi] = CH_W'((int'(rr_ptr_reg) + gi) % NUM_CH);
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending_reg[rot_idx[k]]) begin
        arb_found = 1'b1;
        arb_idx   = rot_idx[k];
      end
    end
  end

  assign sel_inc     = CH_W'((int'(sel_reg) + 1) % NUM_CH);
  assign release_req = (state_reg == S_DONE) || ((state_reg == S_FAIL) && fail_clr);

  // A done pulse on the releasing edge re-queues the channel, so set is applied after clear
  always_comb begin
    pending_next = pending_reg;
    if (release_req) begin
      pending_next[sel_reg] = 1'b0;
    end
    pending_next = pending_next | done;
  end

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    sel_next     = sel_reg;
    retry_next   = retry_reg;
    backoff_next = backoff_reg;
    fail_ch_next = fail_ch_reg;
    case (state_reg)
      S_IDLE: begin
        if (arb_found) begin
          state_next = S_CHECK;
          sel_next   = arb_idx;
          retry_next = '0;
        end
      end
      S_CHECK: state_next = S_START;
      S_START: begin
        if (buffer_ready) begin
          state_next = S_GRANTED;
        end else if (retry_reg < CNT_W'(MAX_RETRY)) begin
          state_next   = S_BACKOFF;
          retry_next   = retry_reg + CNT_W'(1);
          backoff_next = CNT_W'(BACKOFF_CYCLES - 1);
        end else begin
          state_next   = S_FAIL;
          fail_ch_next = sel_reg;
        end
      end
      S_BACKOFF: begin
        if (backoff_reg == '0) begin
          state_next = S_CHECK;
        end else begin
          backoff_next = backoff_reg - CNT_W'(1);
        end
      end
      S_GRANTED: state_next = S_DONE;
      S_DONE: begin
        state_next  = S_IDLE;
        rr_ptr_next = sel_inc;
      end
      S_FAIL: begin
        if (fail_clr) begin
          state_next  = S_IDLE;
          rr_ptr_next = sel_inc;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      sel_reg     <= '0;
      retry_reg   <= '0;
      backoff_reg <= '0;
      fail_ch_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
      sel_reg     <= sel_next;
      retry_reg   <= retry_next;
      backoff_reg <= backoff_next;
      fail_ch_reg <= fail_ch_next;
    end
  end

  assign buffer_write_en = (state_reg == S_CHECK);
  assign buffer_ch_sel   = (state_reg != S_IDLE) ? sel_reg : '0;
  assign stall           = (state_reg == S_DONE) ? 2'b10 :
                           (state_reg == S_FAIL) ? 2'b11 : 2'b00;
  assign fail            = (state_reg == S_FAIL);
  assign fail_ch         = fail_ch_reg;
  assign retry_cnt       = retry_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ack
    assign ch_ack[gi] = (state_reg == S_DONE) && (sel_reg == CH_W'(gi));
  end

endmodule

// File: tb/tb_multi_write_buffer_controller.sv
// Scoreboard bench for multi_write_buffer_controller: stimulus queues expected writes/acks/failures
// with their cycle numbers; a negedge monitor pops and compares whenever the DUT shows one.
module tb_multi_write_buffer_controller;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] done = '0;
  logic              buffer_ready = 1'b0;
  logic              fail_clr = 1'b0;
  logic              buffer_write_en;
  logic [CH_W-1:0]   buffer_ch_sel;
  logic [1:0]        stall;
  logic [NUM_CH-1:0] ch_ack;
  logic              fail;
  logic [CH_W-1:0]   fail_ch;
  logic [CNT_W-1:0]  retry_cnt;

  multi_write_buffer_controller #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .MAX_RETRY(2), .BACKOFF_CYCLES(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .done(done), .buffer_ready(buffer_ready), .fail_clr(fail_clr),
    .buffer_write_en(buffer_write_en), .buffer_ch_sel(buffer_ch_sel), .stall(stall),
    .ch_ack(ch_ack), .fail(fail), .fail_ch(fail_ch), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = write strobe, 1 = ack, 2 = entry into failure
  typedef struct {
    int kind;
    int at;
    int ch;
    int retry;
  } ev_t;

  ev_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  logic fail_prev = 1'b0;

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input int ch, input int retry);
    ev_t e;
    e = '{kind, at, ch, retry};
    sb_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    bit  ok;
    int  got_ch;
    got_ch = (kind == 0) ? int'(buffer_ch_sel) : (kind == 1) ? int'(ch_ack) : int'(fail_ch);
    if (sb_q.size() == 0) begin
      chk(1'b0, "unexpected", $sformatf("got kind=%0d cyc=%0d ch/ack=%0d stall=%b, required nothing",
                                         kind, cyc, got_ch, stall));
      return;
    end
    e = sb_q.pop_front();
    case (kind)
      0:       ok = (e.kind == 0) && (e.at == cyc) && (int'(buffer_ch_sel) == e.ch) &&
                    (int'(retry_cnt) == e.retry);
      1:       ok = (e.kind == 1) && (e.at == cyc) && (ch_ack == (4'b0001 << e.ch)) &&
                    (stall == 2'b10);
      default: ok = (e.kind == 2) && (e.at == cyc) && (int'(fail_ch) == e.ch) && (stall == 2'b11);
    endcase
    $display("txn kind=%0d cyc=%0d ch/ack=%0d retry=%0d stall=%b (required kind=%0d cyc=%0d ch=%0d retry=%0d)",
             kind, cyc, got_ch, retry_cnt, stall, e.kind, e.at, e.ch, e.retry);
    chk(ok, "event", $sformatf("got kind=%0d cyc=%0d ch/ack=%0d retry=%0d stall=%b, required kind=%0d cyc=%0d ch=%0d retry=%0d",
                               kind, cyc, got_ch, retry_cnt, stall, e.kind, e.at, e.ch, e.retry));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (buffer_write_en) take(0);
      if (ch_ack != '0) take(1);
      if (fail && !fail_prev) take(2);
    end
    fail_prev = fail;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] v);
    done = v;
    @(negedge clk);
    done = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(sb_q.size() == 0, name, $sformatf("outstanding events=%0d, required 0", sb_q.size()));
    sb_q.delete();
    step(2);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(buffer_write_en == 1'b0 && buffer_ch_sel == '0 && stall == 2'b00 && ch_ack == '0 &&
        fail == 1'b0 && fail_ch == '0 && retry_cnt == '0, name,
        $sformatf("got we=%b sel=%0d stall=%b ack=%b fail=%b fail_ch=%0d retry=%0d, required all 0",
                  buffer_write_en, buffer_ch_sel, stall, ch_ack, fail, fail_ch, retry_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    step(2);
    chk_idle_outputs("reset");
    rst = 1'b0;
    step(2);

    // Single request on ch0
    t = cyc;
    buffer_ready = 1'b1;
    expect_ev(0, t + 2, 0, 0);
    expect_ev(1, t + 5, 0, 0);
    pulse(4'b0001);
    drain("t1_drain");

    // Simultaneous ch1 and ch3
    t = cyc;
    expect_ev(0, t + 2, 1, 0);
    expect_ev(1, t + 5, 1, 0);
    expect_ev(0, t + 7, 3, 0);
    expect_ev(1, t + 10, 3, 0);
    pulse(4'b1010);
    drain("t2_drain");

    // Re-request in the DONE cycle gets served again
    t = cyc;
    expect_ev(0, t + 2, 0, 0);
    expect_ev(1, t + 5, 0, 0);
    expect_ev(0, t + 7, 0, 0);
    expect_ev(1, t + 10, 0, 0);
    pulse(4'b0001);
    wait_cyc(t + 5);
    pulse(4'b0001);
    drain("t5_drain");

    // Pointer now at 1: ch3 before ch0 (wrap)
    t = cyc;
    expect_ev(0, t + 2, 3, 0);
    expect_ev(1, t + 5, 3, 0);
    expect_ev(0, t + 7, 0, 0);
    expect_ev(1, t + 10, 0, 0);
    pulse(4'b1001);
    drain("wrap_drain");

    // One refusal then success
    t = cyc;
    buffer_ready = 1'b0;
    expect_ev(0, t + 2, 3, 0);
    expect_ev(0, t + 7, 3, 1);
    expect_ev(1, t + 10, 3, 0);
    pulse(4'b1000);
    wait_cyc(t + 4);
    chk(retry_cnt == 4'd1, "t3_retry", $sformatf("got %0d, required 1", retry_cnt));
    buffer_ready = 1'b1;
    drain("t3_drain");

    // Persistent refusal on ch2, ch0 queued during FAIL
    t = cyc;
    buffer_ready = 1'b0;
    expect_ev(0, t + 2, 2, 0);
    expect_ev(0, t + 7, 2, 1);
    expect_ev(0, t + 12, 2, 2);
    expect_ev(2, t + 14, 2, 0);
    expect_ev(0, t + 22, 0, 0);
    expect_ev(1, t + 25, 0, 0);
    pulse(4'b0100);
    wait_cyc(t + 15);
    pulse(4'b0001);
    wait_cyc(t + 19);
    chk(fail == 1'b1 && stall == 2'b11 && fail_ch == 2'd2 && ch_ack == '0, "t4_hold",
        $sformatf("got fail=%b stall=%b fail_ch=%0d ack=%b, required 1 11 2 0000", fail, stall, fail_ch, ch_ack));
    wait_cyc(t + 20);
    fail_clr = 1'b1;
    buffer_ready = 1'b1;
    step(1);
    fail_clr = 1'b0;
    chk(fail == 1'b0 && stall == 2'b00 && fail_ch == 2'd2 && buffer_write_en == 1'b0, "t4_clear",
        $sformatf("got fail=%b stall=%b fail_ch=%0d we=%b, required 0 00 2 0", fail, stall, fail_ch, buffer_write_en));
    drain("t4_drain");

    // Reset during BACKOFF with ch1 and ch2 pending
    t = cyc;
    buffer_ready = 1'b0;
    expect_ev(0, t + 2, 1, 0);
    done = 4'b0010;
    step(1);
    done = 4'b0100;
    step(1);
    done = '0;
    wait_cyc(t + 4);
    chk(retry_cnt == 4'd1 && buffer_write_en == 1'b0, "t6_backoff",
        $sformatf("got retry=%0d we=%b, required 1 0", retry_cnt, buffer_write_en));
    wait_cyc(t + 5);
    rst = 1'b1;
    step(1);
    chk_idle_outputs("t6_reset");
    rst = 1'b0;
    buffer_ready = 1'b1;
    step(15);
    chk(sb_q.size() == 0 && buffer_write_en == 1'b0, "t6_quiet",
        $sformatf("got outstanding=%0d we=%b, required 0 0", sb_q.size(), buffer_write_en));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
